// File: rtl/mmio_data_mem.sv
// MEM-stage data RAM plus memory-mapped TH/TL/TCON timer, LED, DIGI display and SYSTICK counter.
// Optional HW_SCAN_EN macro: hardware multiplexed 7-segment scan of DIGI as four hex nibbles.
module mmio_data_mem #(
  parameter int RAM_AW   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [15:0] led,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        irq
);

  localparam logic [26:0] PER_BASE = 27'h200_0000;  // 0x4000_0000 >> 5

  logic [31:0] r_ram [0:(2**RAM_AW)-1];
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [15:0] r_led;
  logic [15:0] r_digi;
  logic [31:0] r_systick;

  logic              w_ram_sel;
  logic              w_per_sel;
  logic [2:0]        w_reg;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_th;
  logic              w_wr_tl;
  logic              w_wr_tcon;
  logic              w_wr_led;
  logic              w_wr_digi;
  logic              w_ovf;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_ram_sel = (Address[31:RAM_AW+2] == '0);
  assign w_per_sel = (Address[31:5] == PER_BASE);
  assign w_reg     = Address[4:2];
  assign w_ram_idx = Address[RAM_AW+1:2];

  assign w_wr_th   = MemWrite & w_per_sel & (w_reg == 3'd0);
  assign w_wr_tl   = MemWrite & w_per_sel & (w_reg == 3'd1);
  assign w_wr_tcon = MemWrite & w_per_sel & (w_reg == 3'd2);
  assign w_wr_led  = MemWrite & w_per_sel & (w_reg == 3'd3);
  assign w_wr_digi = MemWrite & w_per_sel & (w_reg == 3'd4);

  assign w_ovf = r_tcon[0] & (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_sel) begin
      r_ram[w_ram_idx] <= WriteData;
    end
  end

  // Store beats tick on TL; hardware overflow beats software clear on TCON[2].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= WriteData;
      end
      if (w_wr_tl) begin
        r_tl <= WriteData;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (r_tcon[0]) begin
        r_tl <= r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_tcon <= {WriteData[2] | w_ovf, WriteData[1:0]};
      end else if (w_ovf) begin
        r_tcon[2] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_wr_led) begin
        r_led <= WriteData[15:0];
      end
      if (w_wr_digi) begin
        r_digi <= WriteData[15:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_sel) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_per_sel) begin
      case (w_reg)
        3'd0:    w_rdata = r_th;
        3'd1:    w_rdata = r_tl;
        3'd2:    w_rdata = {29'd0, r_tcon};
        3'd3:    w_rdata = {16'd0, r_led};
        3'd4:    w_rdata = {16'd0, r_digi};
        3'd5:    w_rdata = r_systick;
        default: w_rdata = '0;
      endcase
    end
  end

  assign ReadData = MemRead ? w_rdata : 32'd0;
  assign led      = r_led;
  assign irq      = r_tcon[1] & r_tcon[2];

`ifdef HW_SCAN_EN
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_nib = r_digi[{r_digit, 2'b00} +: 4];

  // Active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  assign AN       = ~(4'b0001 << r_digit);
  assign BCD      = {1'b1, w_seg};
  assign w_unused = &{1'b0, Address[1:0]};
`else
  // Separate output registers keep the display blank after reset until software first writes DIGI.
  logic [3:0] r_an;
  logic [7:0] r_bcd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'hF;
      r_bcd <= 8'hFF;
    end else if (w_wr_digi) begin
      r_an  <= WriteData[11:8];
      r_bcd <= WriteData[7:0];
    end
  end

  assign AN       = r_an;
  assign BCD      = r_bcd;
  assign w_unused = &{1'b0, Address[1:0], (SCAN_DIV == 0)};
`endif

endmodule

// File: tb/tb_mmio_data_mem.sv
// Directed bench for mmio_data_mem: RAM, timer overflow/collisions, peripherals, display, async reset.
module tb_mmio_data_mem;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [15:0] led;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        irq;

  int n_chk;
  int n_bad;

  mmio_data_mem #(.RAM_AW(8), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .led       (led),
    .AN        (AN),
    .BCD       (BCD),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
  endtask

  logic [31:0] v;
  logic [31:0] s0;
  logic [31:0] s1;

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    Address   = '0;
    WriteData = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    #22;

    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
`ifdef HW_SCAN_EN
    chk("rst_an", {28'd0, AN}, 32'hE);
    chk("rst_bcd", {24'd0, BCD}, 32'hC0);
`else
    chk("rst_an", {28'd0, AN}, 32'hF);
    chk("rst_bcd", {24'd0, BCD}, 32'hFF);
`endif
    rd(A_TCON, v); chk("rst_tcon", v, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v); chk("ram_rd", v, 32'hDEAD_BEEF);
    rd(32'h0000_0013, v); chk("ram_lowbits", v, 32'hDEAD_BEEF);
    rd(32'h0000_0014, v); chk("ram_empty", v, 32'd0);
    Address = 32'h0000_0010; MemRead = 1'b0; #1;
    chk("rd_gated", ReadData, 32'd0);

    // Timer overflow after three ticks
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    rd(A_TL, v);   chk("ovf_tl", v, 32'hFFFF_FFFC);
    rd(A_TCON, v); chk("ovf_tcon", v, 32'd7);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    wr(A_TCON, 32'd3);
    rd(A_TCON, v); chk("clr_tcon", v, 32'd3);
    chk("clr_irq", {31'd0, irq}, 32'd0);

    // TCON store landing on the next overflow edge
    repeat (2) @(posedge clk);
    #1;
    wr(A_TCON, 32'd3);
    rd(A_TCON, v); chk("coll_tcon", v, 32'd7);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    rd(A_TL, v);   chk("coll_tl_reload", v, 32'hFFFF_FFFC);

    // TL store on a tick edge wins over increment
    wr(A_TL, 32'h0000_0100);
    rd(A_TL, v);   chk("tl_store_wins", v, 32'h0000_0100);
    wr(A_TCON, 32'd0);
    rd(A_TL, v);   chk("tl_last_tick", v, 32'h0000_0101);
    repeat (3) @(posedge clk);
    #1;
    rd(A_TL, v);   chk("tl_stopped", v, 32'h0000_0101);
    rd(A_TCON, v); chk("tcon_off", v, 32'd0);

    // Peripherals
    wr(A_LED, 32'h1234_ABCD);
    chk("led_out", {16'd0, led}, 32'h0000_ABCD);
    rd(A_LED, v); chk("led_rd", v, 32'h0000_ABCD);

    Address = A_TICK; MemRead = 1'b1; #1;
    s0 = ReadData;
    WriteData = 32'd0; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    s1 = ReadData;
    chk("tick_wr_ignored", s1, s0 + 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("tick_delta5", ReadData, s1 + 32'd5);

    rd(32'h4000_0020, v); chk("unmapped", v, 32'd0);

    // Display
`ifdef HW_SCAN_EN
    wr(A_DIGI, 32'h0000_81F0);
    begin
      int guard;
      logic [3:0]  exp_an [0:3];
      logic [7:0]  exp_bcd [0:3];
      exp_an[0] = 4'b1110; exp_bcd[0] = 8'hC0;
      exp_an[1] = 4'b1101; exp_bcd[1] = 8'h8E;
      exp_an[2] = 4'b1011; exp_bcd[2] = 8'hF9;
      exp_an[3] = 4'b0111; exp_bcd[3] = 8'h80;
      guard = 0;
      while (AN !== 4'b0111 && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      guard = 0;
      while (AN !== 4'b1110 && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      chk("scan_sync", {28'd0, AN}, 32'hE);
      for (int k = 0; k < 20; k++) begin
        chk("scan_an", {28'd0, AN}, {28'd0, exp_an[(k / 4) % 4]});
        chk("scan_bcd", {24'd0, BCD}, {24'd0, exp_bcd[(k / 4) % 4]});
        @(posedge clk); #1;
      end
    end
`else
    wr(A_DIGI, 32'h0000_0E12);
    chk("digi_an", {28'd0, AN}, 32'hE);
    chk("digi_bcd", {24'd0, BCD}, 32'h12);
    rd(A_DIGI, v); chk("digi_rd", v, 32'h0000_0E12);
`endif

    // Async reset while the timer is running with irq asserted
    wr(A_TH, 32'd0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_led", {16'd0, led}, 32'd0);
`ifdef HW_SCAN_EN
    chk("arst_an", {28'd0, AN}, 32'hE);
    chk("arst_bcd", {24'd0, BCD}, 32'hC0);
`else
    chk("arst_an", {28'd0, AN}, 32'hF);
    chk("arst_bcd", {24'd0, BCD}, 32'hFF);
`endif
    rd(A_TL, v);   chk("arst_tl", v, 32'd0);
    rd(A_TCON, v); chk("arst_tcon", v, 32'd0);
    rd(A_TICK, v); chk("arst_tick", v, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
